// File: rtl/fifo_umbrales.sv
// rtl/fifo_umbrales.sv - synchronous FIFO with loadable almost-full/almost-empty thresholds
// Single clock, registered read port, sticky overflow/underflow error flag.
module fifo_umbrales #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  fifo_error
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] alto_q, alto_d;
  logic [ADDR_WIDTH-1:0] bajo_q, bajo_d;

  logic is_empty, is_full;
  logic pop_ok, push_ok;
  logic overflow, underflow;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // A pop needs data present at the start of the cycle, so an empty FIFO
  // never falls through; a full FIFO accepts a push only alongside a pop.
  assign pop_ok    = rd_enable && !is_empty;
  assign push_ok   = wr_enable && (!is_full || pop_ok);
  assign overflow  = wr_enable && !push_ok;
  assign underflow = rd_enable && is_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q;
    alto_d     = alto_q;
    bajo_d     = bajo_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem[rd_ptr_q];
      valid_d    = 1'b1;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end

    // Clearing through init takes priority over a same-cycle error event.
    if (init) begin
      error_d = 1'b0;
      alto_d  = umbral_alto;
      bajo_d  = umbral_bajo;
    end else if (overflow || underflow) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      alto_q     <= '1;
      bajo_q     <= PTR_ONE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
    end
  end

  // Storage is not reset; the occupancy count keeps unwritten words unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign fifo_error   = error_q;
  assign fifo_empty   = is_empty;
  assign fifo_full    = is_full;
  assign almost_full  = (count_q >= {1'b0, alto_q});
  assign almost_empty = (count_q <= {1'b0, bajo_q});

endmodule

// File: tb/tb_fifo_umbrales.sv
// tb/tb_fifo_umbrales.sv - self-checking bench for fifo_umbrales
// Reference queue model feeds an expected-output scoreboard popped on valid_out.
module tb_fifo_umbrales;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic       wr_enable;
  logic [5:0] data_in;
  logic       rd_enable;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic       fifo_error;

  int checks = 0;
  int errors = 0;

  logic [5:0] model[$];
  logic [5:0] exp_q[$];
  logic       m_err = 1'b0;

  fifo_umbrales dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_alto (umbral_alto),
    .umbral_bajo (umbral_bajo),
    .wr_enable   (wr_enable),
    .data_in     (data_in),
    .rd_enable   (rd_enable),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .fifo_error  (fifo_error)
  );

  always #5 clk = ~clk;

  // Drives one cycle from a negedge, updates the model, returns at the next negedge.
  task automatic drive(input logic wr, input logic [5:0] d, input logic rd,
                       input logic ini, output logic popped);
    logic was_empty;
    logic push_ok;
    was_empty = (model.size() == 0);
    popped    = rd && !was_empty;
    push_ok   = wr && (model.size() < 16 || popped);
    wr_enable = wr;
    data_in   = d;
    rd_enable = rd;
    init      = ini;
    if (popped) exp_q.push_back(model.pop_front());
    if (push_ok) model.push_back(d);
    if (ini) m_err = 1'b0;
    else if ((wr && !push_ok) || (rd && was_empty)) m_err = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    init      = 1'b0;
  endtask

  task automatic test_reset();
    logic p;
    reset = 1'b1; init = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
    data_in = '0; umbral_alto = '0; umbral_bajo = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({fifo_empty, almost_empty, fifo_full, almost_full, valid_out, fifo_error, data_out} !== {6'b110000, 6'h00})
      begin errors++; $display("FAIL reset_outputs: got e=%b ae=%b f=%b af=%b v=%b err=%b d=%h want 1 1 0 0 0 0 00",
        fifo_empty, almost_empty, fifo_full, almost_full, valid_out, fifo_error, data_out); end
    drive(1'b0, 6'h00, 1'b0, 1'b0, p);
    checks++;
    if (fifo_empty !== 1'b1 || valid_out !== 1'b0)
      begin errors++; $display("FAIL reset_idle: got e=%b v=%b want e=1 v=0", fifo_empty, valid_out); end
  endtask

  task automatic test_basic();
    logic p;
    logic [5:0] e;
    for (int i = 1; i <= 3; i++) drive(1'b1, 6'(i), 1'b0, 1'b0, p);
    checks++;
    if (fifo_empty !== 1'b0 || almost_empty !== 1'b0 || fifo_full !== 1'b0)
      begin errors++; $display("FAIL basic_flags3: got e=%b ae=%b f=%b want 0 0 0", fifo_empty, almost_empty, fifo_full); end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 6'h00, 1'b1, 1'b0, p);
      e = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || data_out !== e || data_out !== 6'(i))
        begin errors++; $display("FAIL basic_pop%0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, e); end
    end
    drive(1'b0, 6'h00, 1'b0, 1'b0, p);
    checks++;
    if (fifo_empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 6'h03)
      begin errors++; $display("FAIL basic_after: got e=%b v=%b d=%h want e=1 v=0 d=03", fifo_empty, valid_out, data_out); end
  endtask

  task automatic test_thresholds();
    logic p;
    logic [5:0] e;
    umbral_alto = 4'd12; umbral_bajo = 4'd3;
    drive(1'b0, 6'h00, 1'b0, 1'b1, p);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 6'(k + 8), 1'b0, 1'b0, p);
      checks++;
      if (almost_full !== (k >= 12) || almost_empty !== (k <= 3))
        begin errors++; $display("FAIL thr_push%0d: got af=%b ae=%b want af=%b ae=%b",
          k, almost_full, almost_empty, k >= 12, k <= 3); end
    end
    umbral_alto = 4'd13;
    drive(1'b0, 6'h00, 1'b0, 1'b1, p);
    checks++;
    if (almost_full !== 1'b0)
      begin errors++; $display("FAIL thr_reload13: got af=%b want 0", almost_full); end
    umbral_alto = 4'd12;
    drive(1'b0, 6'h00, 1'b0, 1'b1, p);
    checks++;
    if (almost_full !== 1'b1)
      begin errors++; $display("FAIL thr_reload12: got af=%b want 1", almost_full); end
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 6'h00, 1'b1, 1'b0, p);
      e = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || data_out !== e)
        begin errors++; $display("FAIL thr_drain%0d: got v=%b d=%h want v=1 d=%h", k, valid_out, data_out, e); end
    end
    umbral_alto = 4'd15; umbral_bajo = 4'd1;
    drive(1'b0, 6'h00, 1'b0, 1'b1, p);
  endtask

  task automatic test_overflow();
    logic p;
    logic [5:0] e;
    for (int i = 0; i < 16; i++) drive(1'b1, 6'(i * 3 + 1), 1'b0, 1'b0, p);
    checks++;
    if (fifo_full !== 1'b1 || fifo_error !== 1'b0 || almost_full !== 1'b1)
      begin errors++; $display("FAIL ovf_fill: got f=%b err=%b af=%b want 1 0 1", fifo_full, fifo_error, almost_full); end
    drive(1'b1, 6'h2A, 1'b0, 1'b0, p);
    checks++;
    if (fifo_full !== 1'b1 || fifo_error !== m_err || fifo_error !== 1'b1)
      begin errors++; $display("FAIL ovf_17th: got f=%b err=%b want f=1 err=1", fifo_full, fifo_error); end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 6'h00, 1'b1, 1'b0, p);
      e = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || data_out !== e)
        begin errors++; $display("FAIL ovf_pop%0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, e); end
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_error !== 1'b1)
      begin errors++; $display("FAIL ovf_sticky: got e=%b err=%b want e=1 err=1", fifo_empty, fifo_error); end
    drive(1'b0, 6'h00, 1'b0, 1'b1, p);
    checks++;
    if (fifo_error !== 1'b0)
      begin errors++; $display("FAIL ovf_clear: got err=%b want 0", fifo_error); end
  endtask

  task automatic test_full_push_pop();
    logic p;
    logic [5:0] e;
    for (int i = 0; i < 16; i++) drive(1'b1, 6'(8'h20 + i), 1'b0, 1'b0, p);
    drive(1'b1, 6'h3F, 1'b1, 1'b0, p);
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || data_out !== e || data_out !== 6'h20 || fifo_full !== 1'b1 || fifo_error !== 1'b0)
      begin errors++; $display("FAIL fpp_both: got v=%b d=%h f=%b err=%b want v=1 d=20 f=1 err=0",
        valid_out, data_out, fifo_full, fifo_error); end
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 6'h00, 1'b1, 1'b0, p);
      e = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || data_out !== e)
        begin errors++; $display("FAIL fpp_pop%0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, e); end
    end
    checks++;
    if (data_out !== 6'h3F || fifo_empty !== 1'b1)
      begin errors++; $display("FAIL fpp_last: got d=%h e=%b want d=3f e=1", data_out, fifo_empty); end
  endtask

  task automatic test_underflow();
    logic p;
    logic [5:0] e;
    drive(1'b0, 6'h00, 1'b1, 1'b0, p);
    checks++;
    if (fifo_error !== 1'b1 || valid_out !== 1'b0)
      begin errors++; $display("FAIL udf_pop: got err=%b v=%b want err=1 v=0", fifo_error, valid_out); end
    drive(1'b0, 6'h00, 1'b0, 1'b1, p);
    checks++;
    if (fifo_error !== 1'b0)
      begin errors++; $display("FAIL udf_clear: got err=%b want 0", fifo_error); end
    drive(1'b0, 6'h00, 1'b1, 1'b1, p);
    checks++;
    if (fifo_error !== 1'b0 || valid_out !== 1'b0)
      begin errors++; $display("FAIL udf_init_wins: got err=%b v=%b want err=0 v=0", fifo_error, valid_out); end
    drive(1'b1, 6'h15, 1'b1, 1'b0, p);
    checks++;
    if (fifo_error !== 1'b1 || valid_out !== 1'b0 || fifo_empty !== 1'b0)
      begin errors++; $display("FAIL udf_push_pop_empty: got err=%b v=%b e=%b want err=1 v=0 e=0",
        fifo_error, valid_out, fifo_empty); end
    drive(1'b0, 6'h00, 1'b1, 1'b1, p);
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || data_out !== e || data_out !== 6'h15 || fifo_error !== 1'b0 || fifo_empty !== 1'b1)
      begin errors++; $display("FAIL udf_drain: got v=%b d=%h err=%b e=%b want v=1 d=15 err=0 e=1",
        valid_out, data_out, fifo_error, fifo_empty); end
  endtask

  task automatic test_async_reset();
    logic p;
    logic [5:0] e;
    for (int i = 1; i <= 5; i++) drive(1'b1, 6'(8'h30 + i), 1'b0, 1'b0, p);
    drive(1'b0, 6'h00, 1'b1, 1'b0, p);
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || data_out !== e)
      begin errors++; $display("FAIL ar_prepop: got v=%b d=%h want v=1 d=%h", valid_out, data_out, e); end
    #1 reset = 1'b1;
    #1;
    model.delete();
    exp_q.delete();
    m_err = 1'b0;
    checks++;
    if ({fifo_empty, almost_empty, fifo_full, almost_full, valid_out, fifo_error, data_out} !== {6'b110000, 6'h00})
      begin errors++; $display("FAIL ar_midcycle: got e=%b ae=%b f=%b af=%b v=%b err=%b d=%h want 1 1 0 0 0 0 00",
        fifo_empty, almost_empty, fifo_full, almost_full, valid_out, fifo_error, data_out); end
    #1 reset = 1'b0;
    drive(1'b0, 6'h00, 1'b1, 1'b0, p);
    checks++;
    if (fifo_empty !== 1'b1 || valid_out !== 1'b0 || fifo_error !== 1'b1)
      begin errors++; $display("FAIL ar_first_edge: got e=%b v=%b err=%b want e=1 v=0 err=1",
        fifo_empty, valid_out, fifo_error); end
    drive(1'b1, 6'h07, 1'b0, 1'b1, p);
    drive(1'b0, 6'h00, 1'b1, 1'b0, p);
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || data_out !== e || data_out !== 6'h07 || fifo_empty !== 1'b1)
      begin errors++; $display("FAIL ar_after: got v=%b d=%h e=%b want v=1 d=07 e=1", valid_out, data_out, fifo_empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_thresholds();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_umbrales.md
FIFO_UMBRALES -- requirements
Module: fifo_umbrales

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, meaning the width of each stored word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning the pointer width; DEPTH = 2**ADDR_WIDTH (16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 init  input  1  high = load thresholds from umbral_* inputs and clear fifo_error.
REQ-006 umbral_alto  input  ADDR_WIDTH  almost-full threshold, sampled only while init=1.
REQ-007 umbral_bajo  input  ADDR_WIDTH  almost-empty threshold, sampled only while init=1.
REQ-008 wr_enable  input  1  push request for data_in this cycle.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 rd_enable  input  1  pop request this cycle.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 valid_out  output  1  data_out holds a word popped on the previous edge.
REQ-013 fifo_empty, fifo_full  output  1 each  occupancy = 0 / occupancy = DEPTH.
REQ-014 almost_empty, almost_full  output  1 each  threshold flags feeding the control FSM.
REQ-015 fifo_error  output  1  sticky overflow/underflow indication feeding the FSM error vector.

Function
REQ-016 Storage SHALL be DEPTH x DATA_WIDTH registers with ADDR_WIDTH-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-017 Occupancy SHALL be tracked in an (ADDR_WIDTH+1)-bit counter, range 0..DEPTH.
REQ-018 A push SHALL be accepted when wr_enable=1 and (count<DEPTH or an accepted pop occurs in the same cycle); mem[wr_ptr]<=data_in, wr_ptr++.
REQ-019 A pop SHALL be accepted when rd_enable=1 and count>0 at the start of the cycle; data_out<=mem[rd_ptr], valid_out<=1, rd_ptr++ (latency 1 clock).
REQ-020 Every cycle without an accepted pop SHALL drive valid_out<=0, with data_out holding its last value.
REQ-021 Count update SHALL be: +1 push only, -1 pop only, unchanged for both or neither.
REQ-022 Full with simultaneous push and pop: both SHALL be accepted; count stays DEPTH; the popped word is the oldest, never the incoming one.
REQ-023 Empty with simultaneous push and pop: the push SHALL be accepted, the pop SHALL be an underflow (no fall-through), and count becomes 1.
REQ-024 Overflow (wr_enable=1, full, no pop) SHALL drop data_in, leave the pointers unchanged, and set fifo_error<=1.
REQ-025 Underflow (rd_enable=1, count=0) SHALL leave the pointers unchanged and set fifo_error<=1.
REQ-026 fifo_error SHALL stay set until reset or a cycle with init=1; if init=1 and an error event coincide, the clear wins.
REQ-027 While init=1, thresholds SHALL load on every edge (umbral_alto_reg<=umbral_alto, umbral_bajo_reg<=umbral_bajo); the pointers, count and memory SHALL be unaffected, and push/pop SHALL operate normally.
REQ-028 Flags SHALL be combinational from the registered count and thresholds: fifo_empty=(count==0); fifo_full=(count==DEPTH); almost_full=(count>=umbral_alto_reg); almost_empty=(count<=umbral_bajo_reg).
REQ-029 A threshold change SHALL affect the flags starting the cycle after the loading edge.

Reset
REQ-030 reset=1 SHALL asynchronously force: pointers=0; count=0; data_out=0; valid_out=0; fifo_error=0; umbral_alto_reg=DEPTH-1 (15); umbral_bajo_reg=1.
REQ-031 Memory contents need not be reset; the read path SHALL never expose an unwritten word.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; with reset low, the first edge behaves as from empty.
REQ-033 Flags after reset SHALL be: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.

Verification
REQ-034 Reset, then push 3 words 0x01,0x02,0x03 -> count 3, almost_empty=0, fifo_empty=0; 3 pops -> data_out 0x01,0x02,0x03 on consecutive cycles with valid_out=1, then fifo_empty=1.
REQ-035 init=1 with umbral_alto=12, umbral_bajo=3, then init=0, then 12 pushes -> almost_full rises on the 12th push, almost_empty falls after the 4th push.
REQ-036 Fill to 16, then a 17th push -> fifo_full=1, fifo_error=1, the word is dropped, and 16 pops return the original order.
REQ-037 Full FIFO with simultaneous push 0x3F and pop -> count stays 16, fifo_error=0, and 0x3F emerges as the 16th subsequent pop.
REQ-038 Pop on empty -> fifo_error=1, valid_out=0; one cycle of init=1 -> fifo_error=0.
REQ-039 Push 5 words, assert reset for half a clock between edges -> all outputs reach reset values before the next edge, and fifo_empty=1.
